// File: rtl/bin_pool28.sv
// bin_pool28: majority-pools the binarised selection-box pixel stream into
// CELL x CELL cells and publishes a double-buffered one-bit feature map,
// one MAP_W-bit word per cell row, readable over a registered bus port.
module bin_pool28 #(
  parameter int BOX_W = 224,
  parameter int BOX_H = 224,
  parameter int CELL  = 8,
  parameter int MAP_W = 28
) (
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             cmos_frame_vsync,
  input  logic             cmos_frame_valid,
  input  logic             gray_en,
  input  logic             bin_data,
  input  logic [6:0]       bus_pool_threshold,
  input  logic [4:0]       bus_rd_addr,
  output logic [MAP_W-1:0] bus_rd_data,
  input  logic             bus_done_clr,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             map_valid
);

  localparam int CELLS_X = BOX_W / CELL;
  localparam int MAP_H   = BOX_H / CELL;
  localparam int SUB_W   = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int CC_W    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int AW      = 5;
  localparam int ACC_W   = $clog2(CELL * CELL + 1);
  localparam int CMP_W   = (ACC_W > 7) ? ACC_W : 7;

  typedef enum logic [1:0] {S_IDLE, S_POOL, S_HOLD} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_vs_q;
  logic                   r_vs_qq;
  logic                   w_vs_rise;
  logic                   w_init;
  logic                   w_accept;
  logic                   w_take;
  logic                   w_last;
  logic                   w_at_cell_end;
  logic                   w_at_word_end;
  logic                   w_at_last;
  logic [SUB_W-1:0]       r_sub_col;
  logic [SUB_W-1:0]       r_sub_row;
  logic [CC_W-1:0]        r_cell_col;
  logic [AW-1:0]          r_cell_row;
  logic [6:0]             r_thr;
  logic [MAP_W*ACC_W-1:0] w_acc_flat;
  logic [ACC_W-1:0]       w_acc_sel;
  logic [ACC_W-1:0]       w_sum;
  logic                   w_hit;
  logic [MAP_W-1:0]       r_row_word;
  logic [MAP_W-1:0]       w_row_word;
  logic [MAP_W-1:0]       r_bank [0:2**(AW+1)-1];
  logic                   r_wsel;
  logic                   r_frame_done;
  logic                   r_map_valid;
  logic [7:0]             r_frame_cnt;
  logic [MAP_W-1:0]       r_rd_data;

  assign w_vs_rise = r_vs_q & ~r_vs_qq;
  assign w_accept  = (r_state == S_POOL) && cmos_frame_valid && gray_en;

  // Position decodes come from registers only, so the FSM can use them freely.
  assign w_at_cell_end = (r_sub_row == SUB_W'(CELL - 1)) && (r_sub_col == SUB_W'(CELL - 1));
  assign w_at_word_end = w_at_cell_end && (r_cell_col == CC_W'(CELLS_X - 1));
  assign w_at_last     = w_at_word_end && (r_cell_row == AW'(MAP_H - 1));
  assign w_last        = w_accept && w_at_last;
  // A re-initialising vsync edge discards the pixel of that same cycle.
  assign w_take        = w_accept && !w_init;

  assign w_acc_sel = w_acc_flat[r_cell_col*ACC_W +: ACC_W];
  assign w_sum     = w_acc_sel + ACC_W'(bin_data);
  assign w_hit     = (CMP_W'(w_sum) >= CMP_W'(r_thr));

  // Frame sync is registered twice to find its rising edge.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_vs_q  <= 1'b0;
      r_vs_qq <= 1'b0;
    end else begin
      r_vs_q  <= cmos_frame_vsync;
      r_vs_qq <= r_vs_q;
    end
  end

  // FSM state register.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state; the last pixel wins over a coincident vsync edge.
  always_comb begin
    w_state_next = r_state;
    w_init       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vs_rise) begin
          w_init       = 1'b1;
          w_state_next = S_POOL;
        end
      end
      S_POOL: begin
        if (w_last)         w_state_next = S_HOLD;
        else if (w_vs_rise) w_init       = 1'b1;
      end
      S_HOLD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Raster position split into cell index and offset inside the cell.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n || w_init) begin
      r_sub_col  <= '0;
      r_sub_row  <= '0;
      r_cell_col <= '0;
      r_cell_row <= '0;
    end else if (w_take) begin
      if (r_sub_col == SUB_W'(CELL - 1)) begin
        r_sub_col <= '0;
        if (r_cell_col == CC_W'(CELLS_X - 1)) begin
          r_cell_col <= '0;
          if (r_sub_row == SUB_W'(CELL - 1)) begin
            r_sub_row  <= '0;
            r_cell_row <= r_cell_row + 1'b1;
          end else begin
            r_sub_row <= r_sub_row + 1'b1;
          end
        end else begin
          r_cell_col <= r_cell_col + 1'b1;
        end
      end else begin
        r_sub_col <= r_sub_col + 1'b1;
      end
    end
  end

  // Threshold is frozen per frame so bus writes mid-frame cannot tear a map.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n)      r_thr <= '0;
    else if (w_init) r_thr <= bus_pool_threshold;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAP_W; gi++) begin : g_cell
      logic [ACC_W-1:0] r_acc;
      // One accumulator per cell column, cleared once its cell is decided.
      always_ff @(posedge cam_pclk) begin
        if (!rst_n || w_init) begin
          r_acc <= '0;
        end else if (w_take && (r_cell_col == CC_W'(gi))) begin
          r_acc <= w_at_cell_end ? '0 : r_acc + ACC_W'(bin_data);
        end
      end
      assign w_acc_flat[gi*ACC_W +: ACC_W] = r_acc;
      assign w_row_word[gi] = (r_cell_col == CC_W'(gi)) ? w_hit : r_row_word[gi];
    end
  endgenerate

  // Cell decisions of the current cell row collect here before the bank write.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n || w_init)            r_row_word <= '0;
    else if (w_take && w_at_cell_end) r_row_word <= w_row_word;
  end

  // Back-bank write of a completed cell row; whole words keep this a plain RAM.
  // Every box row is rewritten before a bank is ever shown, so no reset is needed.
  always_ff @(posedge cam_pclk) begin
    if (rst_n && w_take && w_at_word_end) begin
      r_bank[{r_wsel, r_cell_row}] <= w_row_word;
    end
  end

  // Registered front-bank read; unwritten or out-of-range rows read as zero.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (r_map_valid && ({1'b0, bus_rd_addr} < (AW+1)'(MAP_H))) begin
      r_rd_data <= r_bank[{~r_wsel, bus_rd_addr}];
    end else begin
      r_rd_data <= '0;
    end
  end

  // Publish: swap banks and raise the flags; publish beats a same-cycle clear.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_wsel       <= 1'b0;
      r_frame_done <= 1'b0;
      r_map_valid  <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (w_last) begin
      r_wsel       <= ~r_wsel;
      r_frame_done <= 1'b1;
      r_map_valid  <= 1'b1;
      r_frame_cnt  <= r_frame_cnt + 1'b1;
    end else if (bus_done_clr) begin
      r_frame_done <= 1'b0;
    end
  end

  assign bus_rd_data = r_rd_data;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;
  assign map_valid   = r_map_valid;

endmodule
